cargador_programa: RTL
======================

Name: cargador_programa

Overview:
Boot-time program loader upstream of the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word into instruction memory through a dedicated write port, holding the core in reset until the full image is written. Releases the core when loading completes and supports re-load, abort by timeout, and length errors.

Parameters:
DEPTH, 32, instruction memory size in words; legal image length is 1..DEPTH.
ADDR_W, 5, instruction memory word-address width; must satisfy 2**ADDR_W >= DEPTH.
TIMEOUT, 1024, max idle cycles between accepted bytes in LEN/LOAD before ERR; 0 disables.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  single-cycle pulse requesting a (re)load.
byte_valid  in  1  byte_data is valid this cycle.
byte_data  in  8  stream byte.
byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
mem_we  out  1  instruction memory write strobe, one cycle per word.
mem_addr  out  ADDR_W  word address for the write.
mem_wdata  out  32  word to write.
core_reset  out  1  active-high reset to the core; 1 except in RUN.
busy  out  1  high in LEN, LOAD, WRITE.
done  out  1  high in RUN.
error  out  1  high in ERR.

Behaviour:
- All outputs are registered. While reset=0: state=IDLE, core_reset=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0. Counters and the assembly register are cleared.
- Reset asserted mid-load aborts immediately, with no further writes. Words already written stay in memory.
- IDLE: byte_ready=0. start=1 -> LEN.
- LEN: byte_ready=1. On transfer:
  - byte_data=0 or byte_data>DEPTH -> ERR.
  - Otherwise len<=byte_data, word_idx<=0, byte_idx<=0, -> LOAD.
- LOAD: byte_ready=1. On transfer, the byte goes to bits [8*byte_idx+7 : 8*byte_idx] of the assembly register and byte_idx increments mod 4. Accepting the byte with byte_idx=3 -> WRITE.
- WRITE: lasts exactly one cycle, with byte_ready=0, mem_we=1, mem_addr=word_idx, mem_wdata=assembled word.
  - Latency: 4th byte accepted at edge t -> mem_we high during cycle t..t+1.
  - If word_idx=len-1 -> RUN; else word_idx++ and -> LOAD.
- RUN: core_reset=0 and done=1 starting the cycle after WRITE. byte_ready=0. start=1 -> LEN, with core_reset=1 from the next cycle.
- ERR: error=1, core_reset=1, byte_ready=0. start=1 -> LEN with error cleared. Bytes offered in ERR are never accepted.
- Timeout:
  - The idle counter resets on every transfer and on entry to LEN/LOAD.
  - It counts cycles in LEN/LOAD without a transfer. Reaching TIMEOUT -> ERR.
  - Words already written are not rolled back.
- start in LEN/LOAD/WRITE is ignored.
- byte_valid while byte_ready=0 is ignored; the producer must hold the byte.
- A partial word (byte_idx≠0) is discarded on any exit to ERR or reset.
- word_idx never exceeds len-1, so mem_addr never wraps.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, LEN, LOAD, WRITE, RUN, ERR; 3-bit);
  - default DEPTH, ADDR_W and TIMEOUT constants;
  - the instruction width constant (32).
- One sub-module, ensamblador_palabra: byte_idx counter plus the 32-bit little-endian assembly register.
  - Inputs: clear, load strobe, byte.
  - Outputs: word, last_byte flag.
- FSM, word counter and timeout counter live in cargador_programa.

Test Plan:
- Basic load: reset low 3 cycles then high; start; stream 0x02, 0x13,0x05,0x50,0x00, 0xB7,0x02,0x00,0x10 with valid held -> mem_we pulses twice, addr 0 data 0x00500513, addr 1 data 0x100002B7; core_reset falls the cycle after the 2nd write; done=1.
- Backpressure/gaps: same image with byte_valid toggling every other cycle -> identical writes; no byte is double-accepted; byte_ready=0 during WRITE.
- Length errors: length byte 0x00 -> ERR, error=1, no mem_we. Separately, length 0x21 with DEPTH=32 -> ERR. Then start plus a valid length -> error clears and load proceeds.
- Boundary: length 0x20 (32 words) -> 32 writes, addresses 0..31 in order, final address 31; then RUN.
- Timeout: TIMEOUT=16; stop the stream after 2 bytes of word 1 -> ERR exactly 16 cycles after the last transfer; word 0 written, no write for word 1; core_reset stays 1.
- Reset/reload: assert reset mid-word 3 -> all outputs at reset values asynchronously. After release, load 1 word, reach RUN, pulse start -> core_reset=1 the next cycle; new image loads correctly.

Source files
------------

// File: rtl/cargador_programa_pkg.sv
// Shared definitions for the boot-time program loader: state encoding,
// default geometry and the instruction word width.
package cargador_programa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } estado_t;

    localparam int DEPTH_DEF   = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 1024;
    localparam int INSTR_W     = 32;
    localparam int BYTE_W      = 8;

    // States in which the loader owns the instruction memory
    function automatic logic es_ocupado(input estado_t s);
        return (s == ST_LEN) || (s == ST_LOAD) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/cargador_programa_if.sv
// Byte stream (valid/ready) plus instruction-memory write port of the loader.
interface cargador_programa_if
    import cargador_programa_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic               byte_valid;
    logic [BYTE_W-1:0]  byte_data;
    logic               byte_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;

    // master = stream producer / memory side, slave = loader
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ensamblador_palabra.sv
// Little-endian word assembler: four accepted bytes fill one 32-bit word,
// lowest address byte first.
module ensamblador_palabra
    import cargador_programa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [BYTE_W-1:0]  dato,
    output logic [INSTR_W-1:0] word,
    output logic               last_byte
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= 2'd0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            word     <= '0;
        end else if (load) begin
            word[{byte_idx, 3'b000} +: BYTE_W] <= dato;
            byte_idx                            <= byte_idx + 2'd1;
        end
    end

    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/cargador_programa.sv
// Boot loader: takes a length byte then little-endian words over a byte
// stream, writes them to instruction memory and releases the core after.
module cargador_programa
    import cargador_programa_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    cargador_programa_if.slave  bus,
    output logic                core_reset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    estado_t            state, state_nxt;
    logic [ADDR_W-1:0]  word_idx;
    logic [ADDR_W-1:0]  len_m1;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [INSTR_W-1:0] asm_word;
    logic               last_byte;
    logic               xfer;
    logic               len_bad;
    logic               timeout_hit;
    logic               asm_clear;
    logic               asm_load;

    assign xfer        = bus.byte_valid & bus.byte_ready;
    assign len_bad     = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_B);
    assign timeout_hit = (TIMEOUT != 0) && !xfer && (idle_cnt == IDLE_MAX);

    // The assembly register keeps the full word through WRITE so it can
    // feed mem_wdata straight from flops; it is wiped everywhere else.
    assign asm_clear = (state != ST_LOAD) && (state != ST_WRITE);
    assign asm_load  = xfer && (state == ST_LOAD);

    ensamblador_palabra u_ensamblador (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (asm_load),
        .dato      (bus.byte_data),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LEN;
            ST_LEN: begin
                if (xfer)             state_nxt = len_bad ? ST_ERR : ST_LOAD;
                else if (timeout_hit) state_nxt = ST_ERR;
            end
            ST_LOAD: begin
                if (xfer && last_byte) state_nxt = ST_WRITE;
                else if (timeout_hit)  state_nxt = ST_ERR;
            end
            ST_WRITE: state_nxt = (word_idx == len_m1) ? ST_RUN : ST_LOAD;
            ST_RUN:   if (start) state_nxt = ST_LEN;
            ST_ERR:   if (start) state_nxt = ST_LEN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Word counter and image length (stored as len-1 so it fits ADDR_W)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            len_m1   <= '0;
        end else if (state == ST_LEN && xfer && !len_bad) begin
            word_idx <= '0;
            len_m1   <= ADDR_W'(bus.byte_data - 8'd1);
        end else if (state == ST_WRITE && state_nxt == ST_LOAD) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    // Idle counter: cleared on transfers, on state entry and outside LEN/LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (xfer || (state_nxt != state) ||
                     !((state_nxt == ST_LEN) || (state_nxt == ST_LOAD))) begin
            idle_cnt <= '0;
        end else if (TIMEOUT != 0) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            core_reset     <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.byte_ready <= (state_nxt == ST_LEN) || (state_nxt == ST_LOAD);
            bus.mem_we     <= (state_nxt == ST_WRITE);
            core_reset     <= (state_nxt != ST_RUN);
            busy           <= es_ocupado(state_nxt);
            done           <= (state_nxt == ST_RUN);
            error          <= (state_nxt == ST_ERR);
        end
    end

    assign bus.mem_addr  = word_idx;
    assign bus.mem_wdata = asm_word;

endmodule
